// File: rtl/i2c_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : i2c_pkg                                                   |
// | Purpose  : Shared types and constants for the I2C register target.   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package i2c_pkg;

  // Protocol state of the target
  typedef enum logic [2:0] {
    Idle,
    RxByte,
    AckTx,
    TxByte,
    AckRx,
    Ignore
  } state_t;

  // Meaning of the byte currently being received
  typedef enum logic [1:0] {
    Address,
    Pointer,
    Data
  } phase_t;

  localparam logic       ReadBit            = 1'b1;
  localparam logic       WriteBit           = 1'b0;
  localparam int         AddressWidth       = 7;
  localparam logic [6:0] GeneralCallAddress = 7'h00;

endpackage
`default_nettype wire

// File: rtl/i2c_line_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : i2c_line_sync                                             |
// | Purpose  : Synchronise SCL/SDA and derive bit and bus-condition      |
// |            events from the synchronised lines.                       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module i2c_line_sync (
  input  logic clock,
  input  logic reset,
  input  logic scl,
  input  logic sda,
  input  logic driving_low,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_in,
  output logic start_detected,
  output logic stop_detected
);

  // [0] metastable stage, [1] synchronised value, [2] previous synchronised value
  logic [2:0] scl_sr;
  logic [2:0] sda_sr;
  logic       scl_high;

  // Two-flop synchronisers followed by an edge-detect flop; reset to idle bus level
  always_ff @(posedge clock) begin
    if (!reset) begin
      scl_sr <= 3'b111;
      sda_sr <= 3'b111;
    end else begin
      scl_sr <= {scl_sr[1:0], scl};
      sda_sr <= {sda_sr[1:0], sda};
    end
  end

  assign scl_rise = scl_sr[1] & ~scl_sr[2];
  assign scl_fall = ~scl_sr[1] & scl_sr[2];
  assign scl_high = scl_sr[1] & scl_sr[2];
  assign sda_in   = sda_sr[1];

  // Our own ACK/data drive must never be mistaken for a bus condition
  assign start_detected = ~sda_sr[1] & sda_sr[2] & scl_high & ~driving_low;
  assign stop_detected  = sda_sr[1] & ~sda_sr[2] & scl_high & ~driving_low;

endmodule
`default_nettype wire

// File: rtl/i2c_slave_registers.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : i2c_slave_registers                                       |
// | Purpose  : I2C target exposing a small register window through a    |
// |            write strobe and a read-index/read-data port.             |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module i2c_slave_registers
  import i2c_pkg::*;
#(
  parameter logic [6:0] SlaveAddress  = 7'h50,
  parameter int         NrOfRegisters = 16,
  parameter int         IndexWidth    = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  scl,
  inout  wire                   sda,
  output logic                  writeStrobe,
  output logic [IndexWidth-1:0] writeIndex,
  output logic [7:0]            writeData,
  output logic [IndexWidth-1:0] readIndex,
  input  logic [7:0]            readData,
  output logic                  busy,
  output logic                  addressed
);

  state_t                state, state_n;
  phase_t                phase, phase_n;
  logic [2:0]            bit_count, bit_count_n;
  logic [7:0]            shift, shift_n;
  logic                  rw, rw_n;
  logic [IndexWidth-1:0] pointer, pointer_n;
  logic                  sda_low, sda_low_n;
  // AckTx: ACK already driven; AckRx: master ACK seen, next fall loads a byte
  logic                  ack_on, ack_on_n;
  logic                  strobe_n;
  logic [IndexWidth-1:0] write_index_n;
  logic [7:0]            write_data_n;
  logic                  busy_n, addressed_n;
  logic                  load_tx;

  logic       scl_rise, scl_fall, sda_in, start_det, stop_det;
  logic [7:0] rx_byte;

  i2c_line_sync u_line_sync (
    .clock         (clock),
    .reset         (reset),
    .scl           (scl),
    .sda           (sda),
    .driving_low   (sda_low),
    .scl_rise      (scl_rise),
    .scl_fall      (scl_fall),
    .sda_in        (sda_in),
    .start_detected(start_det),
    .stop_detected (stop_det)
  );

  // Byte as it will look once the bit arriving on this rise is shifted in
  assign rx_byte   = {shift[6:0], sda_in};
  assign readIndex = pointer;
  assign sda       = sda_low ? 1'b0 : 1'bz;

  // State register; reset releases SDA on the same edge
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= Idle;
      phase       <= Address;
      bit_count   <= 3'd0;
      shift       <= 8'h00;
      rw          <= WriteBit;
      pointer     <= '0;
      sda_low     <= 1'b0;
      ack_on      <= 1'b0;
      writeStrobe <= 1'b0;
      writeIndex  <= '0;
      writeData   <= 8'h00;
      busy        <= 1'b0;
      addressed   <= 1'b0;
    end else begin
      state       <= state_n;
      phase       <= phase_n;
      bit_count   <= bit_count_n;
      shift       <= shift_n;
      rw          <= rw_n;
      pointer     <= pointer_n;
      sda_low     <= sda_low_n;
      ack_on      <= ack_on_n;
      writeStrobe <= strobe_n;
      writeIndex  <= write_index_n;
      writeData   <= write_data_n;
      busy        <= busy_n;
      addressed   <= addressed_n;
    end
  end

  // Next-state logic: STOP beats START beats normal bit handling
  always_comb begin
    state_n       = state;
    phase_n       = phase;
    bit_count_n   = bit_count;
    shift_n       = shift;
    rw_n          = rw;
    pointer_n     = pointer;
    sda_low_n     = sda_low;
    ack_on_n      = ack_on;
    strobe_n      = 1'b0;
    write_index_n = writeIndex;
    write_data_n  = writeData;
    busy_n        = busy;
    addressed_n   = addressed;
    load_tx       = 1'b0;

    if (stop_det) begin
      state_n     = Idle;
      sda_low_n   = 1'b0;
      ack_on_n    = 1'b0;
      busy_n      = 1'b0;
      addressed_n = 1'b0;
    end else if (start_det) begin
      // Repeated START keeps the pointer so a combined read continues from it
      state_n     = RxByte;
      phase_n     = Address;
      bit_count_n = 3'd0;
      sda_low_n   = 1'b0;
      ack_on_n    = 1'b0;
      busy_n      = 1'b1;
    end else begin
      case (state)
        RxByte: begin
          if (scl_rise) begin
            shift_n     = rx_byte;
            bit_count_n = bit_count + 3'd1;
            if (bit_count == 3'd7) begin
              case (phase)
                Address: begin
                  if (rx_byte[7 -: AddressWidth] == SlaveAddress &&
                      SlaveAddress != GeneralCallAddress) begin
                    addressed_n = 1'b1;
                    rw_n        = rx_byte[0];
                    state_n     = AckTx;
                  end else begin
                    addressed_n = 1'b0;
                    state_n     = Ignore;
                  end
                end
                Pointer: begin
                  pointer_n = IndexWidth'(32'(rx_byte) % NrOfRegisters);
                  state_n   = AckTx;
                end
                default: state_n = AckTx;
              endcase
            end
          end
        end
        AckTx: begin
          if (scl_fall) begin
            if (!ack_on) begin
              sda_low_n = 1'b1;
              ack_on_n  = 1'b1;
              if (phase == Data) begin
                strobe_n      = 1'b1;
                write_index_n = pointer;
                write_data_n  = shift;
                pointer_n     = pointer + IndexWidth'(1);
              end
            end else begin
              ack_on_n = 1'b0;
              if (rw == ReadBit) begin
                load_tx = 1'b1;
              end else begin
                sda_low_n   = 1'b0;
                bit_count_n = 3'd0;
                state_n     = RxByte;
                phase_n     = (phase == Address) ? Pointer : Data;
              end
            end
          end
        end
        TxByte: begin
          if (scl_fall) begin
            if (bit_count == 3'd7) begin
              sda_low_n = 1'b0;
              ack_on_n  = 1'b0;
              state_n   = AckRx;
            end else begin
              bit_count_n = bit_count + 3'd1;
              shift_n     = {shift[6:0], 1'b0};
              sda_low_n   = ~shift[6];
            end
          end
        end
        AckRx: begin
          if (scl_rise) begin
            if (sda_in) state_n  = Ignore;
            else        ack_on_n = 1'b1;
          end else if (scl_fall && ack_on) begin
            ack_on_n = 1'b0;
            load_tx  = 1'b1;
          end
        end
        Ignore:  sda_low_n = 1'b0;
        Idle:    sda_low_n = 1'b0;
        default: state_n   = Idle;
      endcase
    end

    // Fetch the byte at the pointer, post-increment, and put its MSB on the bus
    if (load_tx) begin
      shift_n     = readData;
      pointer_n   = pointer + IndexWidth'(1);
      sda_low_n   = ~readData[7];
      bit_count_n = 3'd0;
      state_n     = TxByte;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_registers.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_i2c_slave_registers                                    |
// | Purpose  : Directed bench acting as I2C master with write/read       |
// |            scoreboards for the register target.                      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_i2c_slave_registers;

  localparam int Q = 10;  // clocks per quarter SCL period

  typedef struct {
    logic [3:0] idx;
    logic [7:0] data;
  } wr_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       scl_m = 1'b1;
  logic       m_low = 1'b0;
  wire        sda;
  logic       writeStrobe;
  logic [3:0] writeIndex;
  logic [7:0] writeData;
  logic [3:0] readIndex;
  logic [7:0] readData;
  logic       busy;
  logic       addressed;

  int   tests = 0;
  int   fails = 0;
  wr_t  wq[$];
  logic [7:0] rq[$];

  pullup (sda);
  assign sda      = m_low ? 1'b0 : 1'bz;
  assign readData = 8'h30 + {4'h0, readIndex};

  always #5 clock = ~clock;

  i2c_slave_registers #(
    .SlaveAddress (7'h50),
    .NrOfRegisters(16),
    .IndexWidth   (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .scl        (scl_m),
    .sda        (sda),
    .writeStrobe(writeStrobe),
    .writeIndex (writeIndex),
    .writeData  (writeData),
    .readIndex  (readIndex),
    .readData   (readData),
    .busy       (busy),
    .addressed  (addressed)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic start_cond();
    m_low = 1'b0; scl_m = 1'b1; ticks(Q);
    m_low = 1'b1; ticks(Q);
    scl_m = 1'b0; ticks(Q);
  endtask

  task automatic rep_start();
    m_low = 1'b0; ticks(Q);
    scl_m = 1'b1; ticks(Q);
    m_low = 1'b1; ticks(Q);
    scl_m = 1'b0; ticks(Q);
  endtask

  task automatic stop_cond();
    m_low = 1'b1; ticks(Q);
    scl_m = 1'b1; ticks(Q);
    m_low = 1'b0; ticks(Q);
  endtask

  task automatic write_bit(input logic b);
    m_low = ~b; ticks(Q);
    scl_m = 1'b1; ticks(2 * Q);
    scl_m = 1'b0; ticks(Q);
  endtask

  task automatic read_bit(output logic b);
    m_low = 1'b0; ticks(Q);
    scl_m = 1'b1; ticks(Q);
    b = (sda !== 1'b0);
    ticks(Q);
    scl_m = 1'b0; ticks(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic master_ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(~master_ack);
  endtask

  // Write scoreboard: every strobe must match the oldest expected write
  always @(negedge clock) begin
    if (writeStrobe) begin
      if (wq.size() == 0) begin
        chk("unexpected_strobe", {28'h0, writeIndex}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = wq.pop_front();
        chk("strobe_index", {28'h0, writeIndex}, {28'h0, e.idx});
        chk("strobe_data", {24'h0, writeData}, {24'h0, e.data});
      end
    end
  end

  initial begin
    logic       ack;
    logic [7:0] d;
    logic [7:0] e;

    // Reset state
    ticks(5);
    chk("rst_sda", {31'h0, sda}, 32'h1);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_addressed", {31'h0, addressed}, 32'h0);
    chk("rst_strobe", {31'h0, writeStrobe}, 32'h0);
    chk("rst_widx", {28'h0, writeIndex}, 32'h0);
    chk("rst_wdata", {24'h0, writeData}, 32'h0);
    chk("rst_ridx", {28'h0, readIndex}, 32'h0);
    reset = 1'b1;
    ticks(Q);

    // Write burst at pointer 3
    start_cond();
    chk("burst_busy_start", {31'h0, busy}, 32'h1);
    write_byte(8'hA0, ack); chk("burst_ack_addr", {31'h0, ack}, 32'h0);
    chk("burst_addressed", {31'h0, addressed}, 32'h1);
    write_byte(8'h03, ack); chk("burst_ack_ptr", {31'h0, ack}, 32'h0);
    wq.push_back('{idx: 4'd3, data: 8'hA5});
    write_byte(8'hA5, ack); chk("burst_ack_d0", {31'h0, ack}, 32'h0);
    wq.push_back('{idx: 4'd4, data: 8'h5A});
    write_byte(8'h5A, ack); chk("burst_ack_d1", {31'h0, ack}, 32'h0);
    chk("burst_busy_pre_stop", {31'h0, busy}, 32'h1);
    stop_cond();
    chk("burst_busy_stop", {31'h0, busy}, 32'h0);
    chk("burst_addr_stop", {31'h0, addressed}, 32'h0);
    chk("burst_queue", wq.size(), 32'h0);

    // Address mismatch: no ACK, never addressed
    start_cond();
    write_byte(8'hA2, ack); chk("nomatch_ack_addr", {31'h0, ack}, 32'h1);
    chk("nomatch_addressed", {31'h0, addressed}, 32'h0);
    write_byte(8'h00, ack); chk("nomatch_ack_data", {31'h0, ack}, 32'h1);
    chk("nomatch_addressed2", {31'h0, addressed}, 32'h0);
    stop_cond();
    chk("nomatch_busy", {31'h0, busy}, 32'h0);

    // Combined read from pointer 7
    start_cond();
    write_byte(8'hA0, ack); chk("rd_ack_addr_w", {31'h0, ack}, 32'h0);
    write_byte(8'h07, ack); chk("rd_ack_ptr", {31'h0, ack}, 32'h0);
    rep_start();
    write_byte(8'hA1, ack); chk("rd_ack_addr_r", {31'h0, ack}, 32'h0);
    rq.push_back(8'h37);
    read_byte(d, 1'b1);
    e = rq.pop_front(); chk("rd_byte0", {24'h0, d}, {24'h0, e});
    rq.push_back(8'h38);
    read_byte(d, 1'b0);
    e = rq.pop_front(); chk("rd_byte1", {24'h0, d}, {24'h0, e});
    stop_cond();
    chk("rd_ridx_end", {28'h0, readIndex}, 32'h9);
    chk("rd_busy", {31'h0, busy}, 32'h0);

    // Pointer wrap on write
    start_cond();
    write_byte(8'hA0, ack); chk("wrap_ack_addr", {31'h0, ack}, 32'h0);
    write_byte(8'h0F, ack); chk("wrap_ack_ptr", {31'h0, ack}, 32'h0);
    wq.push_back('{idx: 4'd15, data: 8'h11});
    write_byte(8'h11, ack); chk("wrap_ack_d0", {31'h0, ack}, 32'h0);
    wq.push_back('{idx: 4'd0, data: 8'h22});
    write_byte(8'h22, ack); chk("wrap_ack_d1", {31'h0, ack}, 32'h0);
    stop_cond();
    chk("wrap_ridx", {28'h0, readIndex}, 32'h1);
    chk("wrap_queue", wq.size(), 32'h0);

    // Abort: STOP after 4 data bits
    start_cond();
    write_byte(8'hA0, ack); chk("abort_ack_addr", {31'h0, ack}, 32'h0);
    write_byte(8'h05, ack); chk("abort_ack_ptr", {31'h0, ack}, 32'h0);
    write_bit(1'b1); write_bit(1'b1); write_bit(1'b0); write_bit(1'b0);
    stop_cond();
    ticks(Q);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_addressed", {31'h0, addressed}, 32'h0);
    chk("abort_ridx", {28'h0, readIndex}, 32'h5);

    // Reset while the target holds the address ACK
    start_cond();
    for (int i = 7; i >= 0; i--) write_bit(i == 7 || i == 5);
    m_low = 1'b0;
    ticks(2);
    chk("mid_ack_driven", {31'h0, sda}, 32'h0);
    reset = 1'b0;
    ticks(1);
    chk("mid_rst_sda", {31'h0, sda}, 32'h1);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    chk("mid_rst_addressed", {31'h0, addressed}, 32'h0);
    chk("mid_rst_widx", {28'h0, writeIndex}, 32'h0);
    chk("mid_rst_wdata", {24'h0, writeData}, 32'h0);
    chk("mid_rst_ridx", {28'h0, readIndex}, 32'h0);
    reset = 1'b1;
    ticks(2);
    scl_m = 1'b1;
    ticks(Q);
    start_cond();
    write_byte(8'hA0, ack); chk("post_ack_addr", {31'h0, ack}, 32'h0);
    write_byte(8'h02, ack); chk("post_ack_ptr", {31'h0, ack}, 32'h0);
    wq.push_back('{idx: 4'd2, data: 8'h77});
    write_byte(8'h77, ack); chk("post_ack_data", {31'h0, ack}, 32'h0);
    stop_cond();
    chk("post_busy", {31'h0, busy}, 32'h0);
    chk("final_queue", wq.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
